// File: rtl/alu_control_unit.sv
// Hardwired T0-T5 sequencer for one three-register ALU instruction.
// Outputs are Moore-decoded from state; IR fields matter only in T3-T5.
module alu_control_unit (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Run,
    input  logic [31:0] IR,
    output logic        PC_Out,
    output logic        MDR_Out,
    output logic        ZLO_Out,
    output logic        PC_In,
    output logic        MDR_In,
    output logic        MAR_In,
    output logic        IR_In,
    output logic        Y_In,
    output logic        ZLO_In,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  CONTROL,
    output logic [15:0] R_Out,
    output logic [15:0] R_In,
    output logic        Done,
    output logic        Illegal
);
    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       op_legal;
    logic [4:0] op_ctl;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    always_comb begin
        op_legal = 1'b1;
        op_ctl   = 5'b00000;
        unique case (opcode)
            5'b00011: op_ctl = 5'b00000;
            5'b00100: op_ctl = 5'b00001;
            5'b01010: op_ctl = 5'b00010;
            5'b01011: op_ctl = 5'b00011;
            5'b00101: op_ctl = 5'b00100;
            5'b00110: op_ctl = 5'b00101;
            5'b00111: op_ctl = 5'b00110;
            5'b01000: op_ctl = 5'b00111;
            5'b01001: op_ctl = 5'b01000;
            default:  op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (Run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   state_d = op_legal ? S_T4 : S_HALT;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = Run ? S_T0 : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PC_Out  = 1'b0;
        MDR_Out = 1'b0;
        ZLO_Out = 1'b0;
        PC_In   = 1'b0;
        MDR_In  = 1'b0;
        MAR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        ZLO_In  = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        CONTROL = 5'b00000;
        R_Out   = 16'h0000;
        R_In    = 16'h0000;
        Done    = 1'b0;
        Illegal = 1'b0;
        unique case (state_q)
            S_T0: begin
                PC_Out = 1'b1;
                MAR_In = 1'b1;
                IncPC  = 1'b1;
                ZLO_In = 1'b1;
            end
            S_T1: begin
                ZLO_Out = 1'b1;
                PC_In   = 1'b1;
                Read    = 1'b1;
                MDR_In  = 1'b1;
            end
            S_T2: begin
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
            end
            S_T3: begin
                R_Out = 16'h0001 << rb;
                Y_In  = 1'b1;
            end
            S_T4: begin
                R_Out   = 16'h0001 << rc;
                ZLO_In  = 1'b1;
                CONTROL = op_ctl;
            end
            S_T5: begin
                ZLO_Out = 1'b1;
                R_In    = 16'h0001 << ra;
                Done    = 1'b1;
            end
            S_HALT: Illegal = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: doc/alu_control_unit.md
# alu_control_unit

Hardwired control sequencer for the datapath. It generates, cycle by cycle, the bus-select, register-enable, memory and ALU `CONTROL` signals needed to fetch and execute one three-register ALU instruction (T0–T5). It sits directly upstream of the datapath, drives its control inputs, and reads back the datapath's IR contents.

## Interface
- No parameters. Register file is fixed at 16 registers; instruction word is 32 bits.
- `Clock` in 1: system clock; all state changes on the rising edge.
- `Clear` in 1: asynchronous, active-low reset.
- `Run` in 1: start request, sampled in IDLE and at the end of T5.
- `IR` in 32: current datapath IR contents. Fields:
  - `IR[31:27]` opcode
  - `IR[26:23]` Ra (destination)
  - `IR[22:19]` Rb
  - `IR[18:15]` Rc
- `PC_Out`, `MDR_Out`, `ZLO_Out` out 1 each: bus source selects.
- `PC_In`, `MDR_In`, `MAR_In`, `IR_In`, `Y_In`, `ZLO_In` out 1 each: register load enables.
- `IncPC`, `Read` out 1 each: PC increment; memory-to-MDR select.
- `CONTROL` out 5: ALU operation code.
- `R_Out` out 16: one-hot register-to-bus select.
- `R_In` out 16: one-hot register load enable.
- `Done` out 1: instruction completed (high during T5).
- `Illegal` out 1: unsupported opcode trapped; sticky until reset.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT. State is held in a registered encoding; outputs are Moore-decoded from state plus `IR`.
- Transitions:
  - IDLE → T0 when `Run`=1, otherwise stay in IDLE.
  - T0 → T1 → T2 → T3 unconditionally.
  - T3 → T4 if the opcode is supported, otherwise T3 → HALT.
  - T4 → T5.
  - T5 → T0 if `Run`=1 (back-to-back), otherwise T5 → IDLE.
  - HALT holds until `Clear`.
- Per-state assertions (every unlisted output is 0):
  - T0: `PC_Out`, `MAR_In`, `IncPC`, `ZLO_In`.
  - T1: `ZLO_Out`, `PC_In`, `Read`, `MDR_In`.
  - T2: `MDR_Out`, `IR_In`.
  - T3: `R_Out[Rb]`, `Y_In`.
  - T4: `R_Out[Rc]`, `ZLO_In`, `CONTROL`=map(opcode).
  - T5: `ZLO_Out`, `R_In[Ra]`, `Done`.
  - HALT: `Illegal`.
- Opcode → `CONTROL` map:
  - add 00011 → 00000
  - sub 00100 → 00001
  - and 01010 → 00010
  - or 01011 → 00011
  - shr 00101 → 00100
  - shra 00110 → 00101
  - shl 00111 → 00110
  - ror 01000 → 00111
  - rol 01001 → 01000
  - Any other opcode is illegal.
- `CONTROL` = 00000 in every state other than T4.
- `R_Out` and `R_In` are always zero or one-hot, never multi-hot. Rb=Rc is legal: the same bit is asserted in both T3 and T4.
- Opcode checking and field decode use `IR` only in T3–T5, i.e. after IR has loaded at the end of T2. `IR` content in T0–T2 is ignored.

## Timing
- Each T-state lasts exactly one clock. A datapath register loads on the rising edge that ends the state asserting its enable.
- Latency: `Run` sampled high in IDLE → T0 on the next edge → `Done` in the 6th cycle after leaving IDLE. Back-to-back throughput is one instruction per 6 clocks.
- Outputs may glitch only while `IR` changes. `IR` is stable from T3 onward, so the T3–T5 selects are glitch-free at the sampling edge.
- Reset: `Clear`=0 forces state to IDLE immediately, including mid-instruction. All outputs go to 0, including `Illegal`, and `CONTROL`=00000. Release is synchronous to the first following edge; the first `Run` is sampled one edge after release.
- `Run` deasserted mid-instruction has no effect; the instruction completes.

## Test plan
- Reset mid-T4 (`Clear` low for 5 ns) → all outputs 0 immediately; state IDLE; `Run`=0 keeps it idle.
- shr: `Run`=1 with IR=0x2A920000 (shr R5,R2,R4) →
  - T3: `R_Out`=0x0004, `Y_In`=1.
  - T4: `R_Out`=0x0010, `CONTROL`=00100, `ZLO_In`=1.
  - T5: `ZLO_Out`=1, `R_In`=0x0020, `Done`=1.
  - Then IDLE.
- add R1,R1,R1 (IR=0x18888000) → T3 and T4 `R_Out`=0x0002; `CONTROL`=00000; T5 `R_In`=0x0002.
- Back-to-back: `Run` held high → T0 immediately follows T5; second instruction's `Done` 6 cycles after the first's.
- Illegal opcode 11111 → HALT after T3; `Illegal`=1 and all other outputs 0 until `Clear`; `Run` ignored.
- Fetch check → T0 asserts exactly `PC_Out`/`MAR_In`/`IncPC`/`ZLO_In`; T1 asserts exactly `ZLO_Out`/`PC_In`/`Read`/`MDR_In`; T2 asserts exactly `MDR_Out`/`IR_In`; `R_Out`/`R_In` are 0 throughout.
